// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and frame timing helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Clock cycles from the start-bit edge to the end of the last stop bit.
   function automatic int frame_cycles(input int data_bits, input int parity,
                                       input int stop_bits, input int clks_per_bit);
      return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered word count; writes are ignored while full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Full comes from the registered count, so a same-edge pop never frees room for a push.
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; serialises queued words back-to-back with
// configurable width, parity, stop bits and baud divisor.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          send_trigger,
   input  logic [DATA_BITS-1:0]          send_data,
   output logic                          usb_rs232_txd,
   output logic                          busy,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int CNT_W = $clog2(frame_cycles(DATA_BITS, PARITY, STOP_BITS, CLKS_PER_BIT));
   localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_IDX    = 4'(DATA_BITS - 1);

   tx_state_t            state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 txd;
   logic                 ovf;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 pop;
   logic                 bit_done;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == PAR_ODD) ? ~^d : ^d;
   endfunction

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (send_trigger),
      .din   (send_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign bit_done      = (baud_cnt == '0);
   // A word is taken either from idle or at the last stop cycle, giving gap-free frames.
   assign pop           = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
   assign usb_rs232_txd = txd;
   assign overflow      = ovf;
   assign busy          = (state != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         txd      <= 1'b1;
         ovf      <= 1'b0;
      end else begin
         ovf <= send_trigger && fifo_full;
         if (pop) begin
            shreg    <= fifo_dout;
            par_bit  <= parity_of(fifo_dout);
            txd      <= 1'b0;
            state    <= ST_START;
            baud_cnt <= BIT_RELOAD;
            bit_idx  <= '0;
         end else begin
            case (state)
               ST_IDLE: txd <= 1'b1;
               ST_START: begin
                  if (bit_done) begin
                     state    <= ST_DATA;
                     txd      <= shreg[0];
                     shreg    <= shreg >> 1;
                     baud_cnt <= BIT_RELOAD;
                  end else begin
                     baud_cnt <= baud_cnt - 1'b1;
                  end
               end
               ST_DATA: begin
                  if (!bit_done) begin
                     baud_cnt <= baud_cnt - 1'b1;
                  end else if (bit_idx != LAST_IDX) begin
                     bit_idx  <= bit_idx + 1'b1;
                     txd      <= shreg[0];
                     shreg    <= shreg >> 1;
                     baud_cnt <= BIT_RELOAD;
                  end else if (PARITY != PAR_NONE) begin
                     state    <= ST_PARITY;
                     txd      <= par_bit;
                     baud_cnt <= BIT_RELOAD;
                  end else begin
                     state    <= ST_STOP;
                     txd      <= 1'b1;
                     baud_cnt <= STOP_RELOAD;
                  end
               end
               ST_PARITY: begin
                  if (bit_done) begin
                     state    <= ST_STOP;
                     txd      <= 1'b1;
                     baud_cnt <= STOP_RELOAD;
                  end else begin
                     baud_cnt <= baud_cnt - 1'b1;
                  end
               end
               ST_STOP: begin
                  if (bit_done) begin
                     state <= ST_IDLE;
                     txd   <= 1'b1;
                  end else begin
                     baud_cnt <= baud_cnt - 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  txd   <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: five parameterisations driven in turn, sampled on the falling edge.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] din;
   logic       trig [5];
   logic       txd  [5];
   logic       busy [5];
   logic       full [5];
   logic       empty[5];
   logic       ovf  [5];
   logic [4:0] lvl_a, lvl_b, lvl_c, lvl_e;
   logic [2:0] lvl_d;
   int         sel;
   logic       txd_m, busy_m;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(4)) u_a (
      .clk(clk), .rst(rst), .send_trigger(trig[0]), .send_data(din[7:0]),
      .usb_rs232_txd(txd[0]), .busy(busy[0]), .fifo_full(full[0]), .fifo_empty(empty[0]),
      .fifo_level(lvl_a), .overflow(ovf[0]));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2)) u_b (
      .clk(clk), .rst(rst), .send_trigger(trig[1]), .send_data(din[7:0]),
      .usb_rs232_txd(txd[1]), .busy(busy[1]), .fifo_full(full[1]), .fifo_empty(empty[1]),
      .fifo_level(lvl_b), .overflow(ovf[1]));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(1)) u_c (
      .clk(clk), .rst(rst), .send_trigger(trig[2]), .send_data(din[7:0]),
      .usb_rs232_txd(txd[2]), .busy(busy[2]), .fifo_full(full[2]), .fifo_empty(empty[2]),
      .fifo_level(lvl_c), .overflow(ovf[2]));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_d (
      .clk(clk), .rst(rst), .send_trigger(trig[3]), .send_data(din[7:0]),
      .usb_rs232_txd(txd[3]), .busy(busy[3]), .fifo_full(full[3]), .fifo_empty(empty[3]),
      .fifo_level(lvl_d), .overflow(ovf[3]));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) u_e (
      .clk(clk), .rst(rst), .send_trigger(trig[4]), .send_data(din[6:0]),
      .usb_rs232_txd(txd[4]), .busy(busy[4]), .fifo_full(full[4]), .fifo_empty(empty[4]),
      .fifo_level(lvl_e), .overflow(ovf[4]));

   always_comb begin
      txd_m  = txd[sel];
      busy_m = busy[sel];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // pat holds the line level per bit period, LSB = start bit; skip = cycles of the frame already elapsed.
   task automatic frame_check(input string tag, input logic [15:0] pat, input int nbits, input int skip);
      logic [3:0] s;
      for (int k = 0; k < nbits * 4; k++) begin
         if (k >= skip) begin
            @(negedge clk);
            s[k % 4] = txd_m;
         end else begin
            s[k % 4] = pat[k / 4];
         end
         if (k % 4 == 3) chk($sformatf("%s_bit%0d", tag, k / 4), 32'(s), 32'({4{pat[k / 4]}}));
      end
   endtask

   task automatic watch_idle(input string tag, input int n);
      int lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (!txd_m) lows++;
      end
      chk(tag, 32'(lows), 32'd0);
   endtask

   task automatic send_one(input int idx, input logic [8:0] d, input string tag);
      sel = idx;
      @(negedge clk);
      din = d;
      trig[idx] = 1'b1;
      @(negedge clk);
      trig[idx] = 1'b0;
      chk({tag, "_not_early"}, 32'(txd_m), 32'd1);
      chk({tag, "_busy_set"}, 32'(busy_m), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      din = '0;
      sel = 0;
      for (int i = 0; i < 5; i++) trig[i] = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rst_txd%0d", i),   32'(txd[i]),   32'd1);
         chk($sformatf("rst_busy%0d", i),  32'(busy[i]),  32'd0);
         chk($sformatf("rst_full%0d", i),  32'(full[i]),  32'd0);
         chk($sformatf("rst_empty%0d", i), 32'(empty[i]), 32'd1);
         chk($sformatf("rst_ovf%0d", i),   32'(ovf[i]),   32'd0);
      end
      chk("rst_lvl_a", 32'(lvl_a), 32'd0);
      chk("rst_lvl_d", 32'(lvl_d), 32'd0);
      rst = 1'b0;

      // 8N1 'Q': 0,1,0,0,0,1,0,1,0,1
      send_one(0, 9'h51, "t1");
      frame_check("t1", 16'h02A2, 10, 0);
      chk("t1_busy_last", 32'(busy_m), 32'd1);
      @(negedge clk);
      chk("t1_busy_drop", 32'(busy_m), 32'd0);
      chk("t1_txd_idle", 32'(txd_m), 32'd1);

      // Even parity of 0x51 is 1, odd parity is 0.
      send_one(1, 9'h51, "t2e");
      frame_check("t2e", 16'h06A2, 11, 0);
      @(negedge clk);
      chk("t2e_busy_drop", 32'(busy_m), 32'd0);
      send_one(2, 9'h51, "t2o");
      frame_check("t2o", 16'h04A2, 11, 0);
      @(negedge clk);
      chk("t2o_busy_drop", 32'(busy_m), 32'd0);

      // "ALEX" on consecutive edges.
      sel = 0;
      @(negedge clk); din = 9'h41; trig[0] = 1'b1;
      @(negedge clk); din = 9'h4C; chk("t3_lvl1", 32'(lvl_a), 32'd1);
      @(negedge clk); din = 9'h45; chk("t3_lvl2", 32'(lvl_a), 32'd1); chk("t3_start", 32'(txd_m), 32'd0);
      @(negedge clk); din = 9'h58; chk("t3_lvl3", 32'(lvl_a), 32'd2);
      @(negedge clk); trig[0] = 1'b0; chk("t3_lvl_peak", 32'(lvl_a), 32'd3);
      frame_check("t3_A", 16'h0282, 10, 3);
      frame_check("t3_L", 16'h0298, 10, 0);
      frame_check("t3_E", 16'h028A, 10, 0);
      frame_check("t3_X", 16'h02B0, 10, 0);
      @(negedge clk);
      chk("t3_busy_drop", 32'(busy_m), 32'd0);

      // Depth-4 FIFO, six writes: the sixth is dropped.
      sel = 3;
      @(negedge clk); din = 9'h11; trig[3] = 1'b1;
      @(negedge clk); din = 9'h22;
      @(negedge clk); din = 9'h33;
      @(negedge clk); din = 9'h44;
      @(negedge clk); din = 9'h55;
      @(negedge clk); din = 9'h66;
      chk("t4_full", 32'(full[3]), 32'd1);
      chk("t4_lvl4", 32'(lvl_d), 32'd4);
      chk("t4_no_ovf_yet", 32'(ovf[3]), 32'd0);
      @(negedge clk); trig[3] = 1'b0;
      chk("t4_ovf_pulse", 32'(ovf[3]), 32'd1);
      chk("t4_lvl_hold", 32'(lvl_d), 32'd4);
      @(negedge clk);
      chk("t4_ovf_clear", 32'(ovf[3]), 32'd0);
      frame_check("t4_w0", 16'h0222, 10, 6);
      frame_check("t4_w1", 16'h0244, 10, 0);
      frame_check("t4_w2", 16'h0266, 10, 0);
      frame_check("t4_w3", 16'h0288, 10, 0);
      frame_check("t4_w4", 16'h02AA, 10, 0);
      @(negedge clk);
      chk("t4_busy_drop", 32'(busy_m), 32'd0);
      watch_idle("t4_no_sixth", 44);

      // Reset during data bit 3 with two words still queued.
      sel = 0;
      @(negedge clk); din = 9'h51; trig[0] = 1'b1;
      @(negedge clk); din = 9'h22;
      @(negedge clk); din = 9'h33;
      @(negedge clk); trig[0] = 1'b0; chk("t5_lvl2", 32'(lvl_a), 32'd2);
      repeat (15) @(negedge clk);
      chk("t5_in_bit3", 32'(txd_m), 32'd0);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("t5_txd", 32'(txd_m), 32'd1);
      chk("t5_empty", 32'(empty[0]), 32'd1);
      chk("t5_busy", 32'(busy_m), 32'd0);
      chk("t5_lvl", 32'(lvl_a), 32'd0);
      watch_idle("t5_no_frames", 100);

      // 7 data bits, 2 stop bits: start then nine high bit periods.
      send_one(4, 9'h07F, "t6");
      frame_check("t6", 16'h03FE, 10, 0);
      @(negedge clk);
      chk("t6_busy_drop", 32'(busy_m), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO; successor to the single-byte send path on usb_rs232_txd. Host logic strobes bytes in with send_trigger/send_data at full clock rate. The block queues them and serialises back-to-back frames with configurable data width, parity, stop bits and baud divisor. It sits between core logic and the board RS-232/USB bridge pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range ≥ 2
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 2

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high
send_trigger  in  1  write strobe; one byte queued per cycle high
send_data  in  DATA_BITS  word sampled when send_trigger=1
usb_rs232_txd  out  1  serial line, idle high
busy  out  1  high while FSM not IDLE or FIFO not empty
fifo_full  out  1  FIFO holds FIFO_DEPTH words
fifo_empty  out  1  FIFO holds zero words
fifo_level  out  $clog2(FIFO_DEPTH)+1  current word count
overflow  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (sync, rst=1 at an edge): usb_rs232_txd=1, busy=0, fifo_full=0, fifo_empty=1, fifo_level=0, overflow=0, FSM=IDLE, pointers=0, bit counters=0.
- Reset mid-frame aborts the frame and discards FIFO contents. txd is high after that edge. No partial stop bit is emitted.
- Write: at an edge with send_trigger=1 and fifo_full=0, send_data is pushed and fifo_level increments.
- Write with fifo_full=1: the word is dropped and overflow=1 for exactly the next cycle. A pop on the same edge does not admit the write, because full is evaluated from the registered count.
- Simultaneous push and pop on the same edge (not full): fifo_level is unchanged and both operations take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with fifo_empty=0 at an edge: pop, load the shift register, txd=0, enter START.
  - Latency: a word written at edge N into an empty idle block drives txd low at edge N+1.
- Bit timing: each state holds txd for exactly CLKS_PER_BIT cycles, counted by a baud counter that is reloaded on every bit transition.
- DATA: LSB first, DATA_BITS bits, tracked by a bit index.
- PARITY: present only if PARITY≠0.
  - Odd mode: the bit makes the total ones count (data + parity) odd.
  - Even mode: the bit is the XOR of the data bits.
- STOP: txd=1 for STOP_BITS×CLKS_PER_BIT cycles.
- At the end of STOP:
  - If the FIFO is non-empty, pop and go directly to START with no idle gap.
  - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- usb_rs232_txd is driven from a register (glitch-free). send_data is not required to be stable after the write edge.
- busy falls on the same edge the FSM enters IDLE with the FIFO empty.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH inclusive.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - FSM state encoding;
  - helper function for frame length.
- One natural sub-module, sync_fifo (WIDTH, DEPTH): single-clock, registered count, full/empty/level outputs, write-ignored-when-full. It is reused later by the receive path.

Test Plan:
1. Default params with CLKS_PER_BIT=4, write 0x51 ("Q") once.
   -> txd = 0,1,0,0,0,1,0,1,0,1, each bit for 4 cycles.
   -> First low at write edge + 1.
   -> busy drops after 40 cycles.
2. PARITY=2, then PARITY=1, write 0x51.
   -> Parity bit is 1 (even mode) and 0 (odd mode), placed before stop.
   -> Frame is 44 cycles.
3. Write 0x41, 0x4C, 0x45, 0x58 ("ALEX") on 4 consecutive cycles.
   -> fifo_level peaks at 3.
   -> Four frames back-to-back with no idle cycle between a stop bit and the next start bit.
   -> Bytes arrive in order.
4. FIFO_DEPTH=4, write 6 words on consecutive cycles while idle.
   -> fifo_full=1 reached.
   -> overflow pulses on the rejected write(s).
   -> Exactly 5 words are transmitted (1 popped early, 4 queued); the dropped word is never sent.
5. Assert rst for 1 cycle during the DATA bit 3 of a frame with 2 words queued.
   -> Next cycle: txd=1, fifo_empty=1, busy=0.
   -> No further frames are sent.
6. STOP_BITS=2, DATA_BITS=7, write 0x7F.
   -> Frame is start, 7 ones, then stop high for 8 cycles.
   -> Total 40 cycles.
